// File: rtl/board_dealer.sv
// Make-ten board owner: deals ten 1..9 tiles from a free-running LFSR, checks
// committed slot pairs, clears and refills matching pairs, and keeps the score.
module board_dealer #(
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter int unsigned SCORE_MAX = 99
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        commit_valid,
  input  logic [3:0]  commit_a,
  input  logic [3:0]  commit_b,
  output logic [39:0] status,
  output logic        busy,
  output logic [6:0]  score,
  output logic        match_pulse,
  output logic        reject_pulse
);

  localparam logic [7:0] SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [6:0] SCORE_LIM = 7'(SCORE_MAX);

  typedef enum logic [2:0] {IDLE, DEAL, READY, REFILL_A, REFILL_B} state_t;

  state_t      state, next_state;
  logic [7:0]  lfsr;
  logic [3:0]  rnd, tile;
  logic [3:0]  cnt, idx_a, idx_b;
  logic [39:0] board;
  logic [3:0]  val_a, val_b;
  logic [4:0]  pair_sum;
  logic        pair_ok, deal_go, accept, refuse;

  // Folds 0..15 onto 1..9 without ever producing an empty tile.
  assign rnd  = lfsr[3:0];
  assign tile = (rnd >= 4'd9) ? (rnd - 4'd8) : (rnd + 4'd1);

  assign status = board;
  assign busy   = (state == DEAL) || (state == REFILL_A) || (state == REFILL_B);

  // Mux-based lookup keeps out-of-range indices from addressing past slot 9.
  always_comb begin
    val_a = '0;
    val_b = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (commit_a == 4'(i)) val_a = board[4*i +: 4];
      if (commit_b == 4'(i)) val_b = board[4*i +: 4];
    end
    pair_sum = {1'b0, val_a} + {1'b0, val_b};
    pair_ok  = (commit_a <= 4'd9) && (commit_b <= 4'd9) && (commit_a != commit_b) &&
               (val_a != '0) && (val_b != '0) && (pair_sum == 5'd10);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    deal_go    = 1'b0;
    accept     = 1'b0;
    refuse     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          deal_go    = 1'b1;
          next_state = DEAL;
        end
      end
      DEAL: begin
        if (cnt == 4'd9) next_state = READY;
      end
      READY: begin
        if (start) begin
          deal_go    = 1'b1;
          next_state = DEAL;
        end else if (commit_valid) begin
          if (pair_ok) begin
            accept     = 1'b1;
            next_state = REFILL_A;
          end else begin
            refuse = 1'b1;
          end
        end
      end
      REFILL_A: next_state = REFILL_B;
      REFILL_B: next_state = READY;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr         <= SEED;
      cnt          <= '0;
      idx_a        <= '0;
      idx_b        <= '0;
      board        <= '0;
      score        <= '0;
      match_pulse  <= 1'b0;
      reject_pulse <= 1'b0;
    end else begin
      lfsr         <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
      match_pulse  <= accept;
      reject_pulse <= refuse;
      if (deal_go) begin
        cnt   <= '0;
        score <= '0;
      end
      case (state)
        DEAL: begin
          for (int unsigned i = 0; i < 10; i++)
            if (cnt == 4'(i)) board[4*i +: 4] <= tile;
          cnt <= cnt + 4'd1;
        end
        READY: begin
          if (accept) begin
            for (int unsigned i = 0; i < 10; i++)
              if ((commit_a == 4'(i)) || (commit_b == 4'(i))) board[4*i +: 4] <= '0;
            idx_a <= commit_a;
            idx_b <= commit_b;
            score <= (score >= SCORE_LIM) ? SCORE_LIM : score + 7'd1;
          end
        end
        REFILL_A: begin
          for (int unsigned i = 0; i < 10; i++)
            if (idx_a == 4'(i)) board[4*i +: 4] <= tile;
        end
        REFILL_B: begin
          for (int unsigned i = 0; i < 10; i++)
            if (idx_b == 4'(i)) board[4*i +: 4] <= tile;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_dealer.sv
// Randomized self-checking bench for board_dealer against a transaction-level
// model of the board, score and tile stream.
module tb_board_dealer;

  localparam int SMAX = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        commit_valid;
  logic [3:0]  commit_a, commit_b;
  logic [39:0] status;
  logic        busy;
  logic [6:0]  score;
  logic        match_pulse, reject_pulse;

  board_dealer #(.LFSR_SEED(8'hA5), .SCORE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .commit_valid(commit_valid),
    .commit_a(commit_a), .commit_b(commit_b), .status(status), .busy(busy),
    .score(score), .match_pulse(match_pulse), .reject_pulse(reject_pulse)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int m_score = 0;
  int sat_hits = 0;
  int mb[10];
  logic [7:0] m_lfsr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Tile stream source: the spec's Galois LFSR, free-running from reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
  end

  always @(negedge clk)
    if (rst_n) check("pulse_excl", 64'(match_pulse & reject_pulse), 64'd0);

  function automatic int tile_of(input logic [7:0] l);
    int r;
    r = int'(l[3:0]);
    return (r >= 9) ? r - 8 : r + 1;
  endfunction

  function automatic logic [39:0] packed_board();
    logic [39:0] p;
    for (int i = 0; i < 10; i++) p[4*i +: 4] = 4'(mb[i]);
    return p;
  endfunction

  function automatic void find_pair(input bit want10, output int pa, output int pb, output bit found);
    int off;
    found = 0; pa = 0; pb = 1;
    off = int'($urandom_range(0, 9));
    for (int x = 0; x < 10; x++)
      for (int j = 0; j < 10; j++) begin
        int i;
        i = (x + off) % 10;
        if (!found && i != j && mb[i] != 0 && mb[j] != 0 && ((mb[i] + mb[j] == 10) == want10)) begin
          found = 1; pa = i; pb = j;
        end
      end
  endfunction

  // Called at a negedge; returns at a negedge with the board in READY.
  task automatic deal(input bit with_commit, input int ca, input int cb);
    int ok;
    start = 1'b1;
    if (with_commit) begin
      commit_valid = 1'b1; commit_a = 4'(ca); commit_b = 4'(cb);
    end
    @(negedge clk);
    start = 1'b0; commit_valid = 1'b0;
    check("deal_no_match", 64'(match_pulse), 64'd0);
    check("deal_no_reject", 64'(reject_pulse), 64'd0);
    for (int k = 0; k < 10; k++) begin
      check("deal_busy", 64'(busy), 64'd1);
      mb[k] = tile_of(m_lfsr);
      @(negedge clk);
    end
    m_score = 0;
    check("deal_done_busy", 64'(busy), 64'd0);
    check("deal_status", 64'(status), 64'(packed_board()));
    check("deal_score", 64'(score), 64'd0);
    ok = 1;
    for (int i = 0; i < 10; i++)
      if (status[4*i +: 4] == 4'd0 || status[4*i +: 4] > 4'd9) ok = 0;
    check("deal_range", 64'(ok), 64'd1);
  endtask

  task automatic commit(input int a, input int b, input bit inject);
    bit ok;
    int ra, rb;
    logic [39:0] prev;
    prev = packed_board();
    ok = (a >= 0 && a <= 9 && b >= 0 && b <= 9 && a != b);
    if (ok) ok = (mb[a] != 0 && mb[b] != 0 && mb[a] + mb[b] == 10);
    commit_valid = 1'b1; commit_a = 4'(a); commit_b = 4'(b);
    @(negedge clk);
    commit_valid = 1'b0;
    commit_a = 4'($urandom); commit_b = 4'($urandom);
    if (ok) begin
      if (m_score == SMAX) sat_hits++;
      if (m_score < SMAX) m_score++;
      mb[a] = 0; mb[b] = 0;
      check("m_match", 64'(match_pulse), 64'd1);
      check("m_reject", 64'(reject_pulse), 64'd0);
      check("m_busy_a", 64'(busy), 64'd1);
      check("m_cleared", 64'(status), 64'(packed_board()));
      check("m_score", 64'(score), 64'(m_score));
      if (inject) begin
        commit_valid = 1'b1; commit_a = 4'(a); commit_b = 4'(b);
      end
      ra = tile_of(m_lfsr);
      @(negedge clk);
      commit_valid = 1'b0;
      mb[a] = ra;
      check("m_pulse_once", 64'(match_pulse), 64'd0);
      check("m_busy_b", 64'(busy), 64'd1);
      check("m_refill_a", 64'(status), 64'(packed_board()));
      rb = tile_of(m_lfsr);
      @(negedge clk);
      mb[b] = rb;
      check("m_busy_done", 64'(busy), 64'd0);
      check("m_refill_b", 64'(status), 64'(packed_board()));
      check("m_no_pulse_after", 64'({match_pulse, reject_pulse}), 64'd0);
      check("m_score_after", 64'(score), 64'(m_score));
    end else begin
      check("r_reject", 64'(reject_pulse), 64'd1);
      check("r_match", 64'(match_pulse), 64'd0);
      check("r_busy", 64'(busy), 64'd0);
      check("r_status", 64'(status), 64'(prev));
      check("r_score", 64'(score), 64'(m_score));
      @(negedge clk);
      check("r_pulse_once", 64'(reject_pulse), 64'd0);
    end
  endtask

  initial begin
    int pa, pb;
    bit found;
    rst_n = 1'b0; start = 1'b0; commit_valid = 1'b0; commit_a = '0; commit_b = '0;
    #23;
    check("rst_status", 64'(status), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_score", 64'(score), 64'd0);
    check("rst_pulses", 64'({match_pulse, reject_pulse}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // IDLE ignores commits
    commit_valid = 1'b1; commit_a = 4'd0; commit_b = 4'd1;
    @(negedge clk);
    commit_valid = 1'b0;
    check("idle_ignore", 64'({match_pulse, reject_pulse, busy}), 64'd0);

    deal(0, 0, 0);
    commit(3, 3, 0);
    commit(10, 2, 0);
    find_pair(0, pa, pb, found);
    if (found) commit(pa, pb, 0);

    found = 0;
    for (int t = 0; t < 30 && !found; t++) begin
      find_pair(1, pa, pb, found);
      if (!found) deal(0, 0, 0);
    end
    check("pair_found", 64'(found), 64'd1);
    if (found) commit(pa, pb, 1);

    // start and commit in the same READY cycle: re-deal wins, no pulse
    find_pair(1, pa, pb, found);
    deal(1, pa, pb);

    for (int it = 0; it < 600 && sat_hits < 2; it++) begin
      find_pair(1, pa, pb, found);
      if (!found) deal(0, 0, 0);
      else if ($urandom_range(0, 2) != 0) commit(pa, pb, $urandom_range(0, 1) == 1);
      else commit(int'($urandom_range(0, 11)), int'($urandom_range(0, 11)), 0);
    end
    check("score_saturated", 64'(sat_hits >= 1), 64'd1);

    // Reset in the middle of a deal
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_status", 64'(status), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_score", 64'(score), 64'd0);
    check("mid_rst_pulses", 64'({match_pulse, reject_pulse}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    commit_valid = 1'b1; commit_a = 4'd1; commit_b = 4'd2;
    @(negedge clk);
    commit_valid = 1'b0;
    check("post_rst_idle", 64'({match_pulse, reject_pulse, busy}), 64'd0);
    check("post_rst_status", 64'(status), 64'd0);
    deal(0, 0, 0);
    find_pair(1, pa, pb, found);
    if (found) commit(pa, pb, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
